pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning architectural register count; index width fixed at 5.
REQ-002 SHALL have ports: cpu_clk  in  1  core clock.
REQ-003 cpu_rstn  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_rR1, id_rR2  in  5 each  ID source register indices.
REQ-006 id_rR1_re, id_rR2_re  in  1 each  ID reads that source (from CU).
REQ-007 id_rf_we  in  1; id_wR  in  5; id_wd_sel  in  2  ID destination write-enable, index, write-back source.
REQ-008 ex_br_taken  in  1  EX resolved a redirect this cycle.
REQ-009 mem_busy  in  1  data memory not ready; the whole pipe must freeze.
REQ-010 pc_stall, ifid_stall  out  1 each  hold PC / IF-ID register.
REQ-011 ifid_flush, idex_flush  out  1 each  load bubble into IF-ID / ID-EX.
REQ-012 fwd1_sel, fwd2_sel  out  2 each  operand source: 0 RF, 1 EX, 2 MEM, 3 WB.
REQ-013 stall_cnt  out  32  count of cycles with pc_stall=1.

Function
REQ-014 SHALL track three slots EX, MEM, WB, each {valid, rf_we, wR[4:0], is_load}; is_load = (wd_sel == WD_RAM).
REQ-015 On each cpu_clk rising edge with mem_busy=0: WB<=MEM, MEM<=EX, EX<=ID info, or EX<=invalid when idex_flush=1.
REQ-016 With mem_busy=1 all slots SHALL hold; pc_stall=ifid_stall=1; both flushes 0.
REQ-017 Slot "writes r" iff valid & rf_we & wR==r & r!=0; register 0 SHALL never cause forwarding or stall.
REQ-018 Forward select per operand (only when its re=1): EX if EX writes it and EX not load; else MEM; else WB; else RF; youngest wins.
REQ-019 Load-use: ID valid, a read operand written by EX slot with is_load=1 -> pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle; next cycle forward from MEM.
REQ-020 ex_br_taken=1 and mem_busy=0 -> ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0; overrides load-use.
REQ-021 Priority: mem_busy > ex_br_taken > load-use hazard > normal flow.
REQ-022 All stall/flush/fwd outputs SHALL be combinational from slot state and current inputs; zero added latency.
REQ-023 stall_cnt SHALL increment by 1 each cycle pc_stall=1 and saturate at 32'hFFFF_FFFF.
REQ-024 id_valid=0 SHALL produce no hazard and insert an invalid EX slot.

Reset
REQ-025 cpu_rstn low SHALL immediately clear all slot valid bits and stall_cnt to 0, independent of cpu_clk.
REQ-026 During and right after reset: pc_stall, ifid_stall, ifid_flush, idex_flush = 0; fwd1_sel = fwd2_sel = 0.
REQ-027 Reset asserted mid-stall or mid-freeze SHALL discard all tracked state; no hazard survives reset.

Configuration
REQ-028 Macro PIPE_FWD_EN defined: forwarding per REQ-018/019.
REQ-029 PIPE_FWD_EN undefined: fwd1_sel = fwd2_sel = 0 constant; any read operand written by EX, MEM or WB slot stalls (pc_stall=ifid_stall=idex_flush=1) until no slot matches; REQ-020/016 unchanged.

Structure
REQ-030 FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings and WD_RAM SHALL live in shared defines.vh.
REQ-031 One sub-module pipe_slot (one slot register with hold/bubble/match logic) SHALL be instantiated three times.

Verification
REQ-032 add r3,r1,r2 then add r4,r3,r5 -> cycle 2 fwd1_sel=1, no stall (FWD on); without PIPE_FWD_EN 3 stall cycles, stall_cnt=3.
REQ-033 ld.w r6 then add r7,r6,r0 -> one cycle pc_stall=ifid_stall=idex_flush=1, next cycle fwd1_sel=2; stall_cnt=1.
REQ-034 Write to r0 then read r0 -> fwd sel 0, no stall.
REQ-035 Load-use hazard with ex_br_taken=1 same cycle -> ifid_flush=idex_flush=1, pc_stall=0; with mem_busy=1 also -> freeze only, no flush.
REQ-036 Producer in MEM and WB both writing r5, consumer reads r5 -> fwd sel 2 (MEM).
REQ-037 Assert cpu_rstn low mid-load-use stall -> all outputs 0 asynchronously, stall_cnt=0, next instruction sees no hazard.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load write-back source code and the per-cycle pipeline action.
package pipe_ctrl_pkg;

  localparam int IDX_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Write-back source code that marks an instruction as a load.
  localparam logic [1:0] WD_RAM = 2'd1;

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_HAZARD,
    ACT_REDIRECT,
    ACT_FREEZE
  } pipe_act_e;

  // Youngest producer wins; a load still in EX has no data yet, so skip it.
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic ex_ld,
                                          input logic mem_hit, input logic wb_hit);
    if (ex_hit && !ex_ld) return FWD_EX;
    if (mem_hit)          return FWD_MEM;
    if (wb_hit)           return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One tracked pipeline slot (EX, MEM or WB): holds on freeze, takes a bubble
// on flush, and reports whether it writes either ID source register.
module pipe_slot
  import pipe_ctrl_pkg::*;
(
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             hold,
  input  logic             bubble,
  input  logic             d_valid,
  input  logic             d_rf_we,
  input  logic [IDX_W-1:0] d_wr,
  input  logic             d_is_load,
  input  logic [IDX_W-1:0] rr1,
  input  logic [IDX_W-1:0] rr2,
  output logic             q_valid,
  output logic             q_rf_we,
  output logic [IDX_W-1:0] q_wr,
  output logic             q_is_load,
  output logic             hit1,
  output logic             hit2
);

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      q_valid   <= 1'b0;
      q_rf_we   <= 1'b0;
      q_wr      <= '0;
      q_is_load <= 1'b0;
    end else if (!hold) begin
      q_valid   <= d_valid & ~bubble;
      q_rf_we   <= d_rf_we;
      q_wr      <= d_wr;
      q_is_load <= d_is_load;
    end
  end

  // r0 is hard-wired zero, so it never produces a match.
  assign hit1 = q_valid & q_rf_we & (q_wr == rr1) & (rr1 != '0);
  assign hit2 = q_valid & q_rf_we & (q_wr == rr2) & (rr2 != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/forward decisions from EX/MEM/WB slots.
// Define PIPE_FWD_EN for bypass forwarding; otherwise any RAW dependency stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_rR1,
  input  logic [IDX_W-1:0] id_rR2,
  input  logic             id_rR1_re,
  input  logic             id_rR2_re,
  input  logic             id_rf_we,
  input  logic [IDX_W-1:0] id_wR,
  input  logic [1:0]       id_wd_sel,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [31:0]      stall_cnt
);

  // Chain index 0 is the ID instruction; 1..3 are the EX, MEM, WB slot outputs.
  logic [3:0]            ch_valid;
  logic [3:0]            ch_rf_we;
  logic [3:0]            ch_is_load;
  logic [3:0][IDX_W-1:0] ch_wr;
  logic [2:0]            hit1;
  logic [2:0]            hit2;
  logic [2:0]            bubble_vec;
  logic                  ex_ld;
  logic                  load_use;
  logic                  hazard;
  logic [1:0]            fwd1_raw;
  logic [1:0]            fwd2_raw;
  logic [31:0]           stall_cnt_reg;
  pipe_act_e             act;
  logic                  unused_wb;

  assign ch_valid[0]   = id_valid;
  assign ch_rf_we[0]   = id_rf_we & (int'(id_wR) < NREG);
  assign ch_wr[0]      = id_wR;
  assign ch_is_load[0] = (id_wd_sel == WD_RAM);
  assign bubble_vec    = {2'b00, idex_flush};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      pipe_slot u_slot (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .hold      (mem_busy),
        .bubble    (bubble_vec[gi]),
        .d_valid   (ch_valid[gi]),
        .d_rf_we   (ch_rf_we[gi]),
        .d_wr      (ch_wr[gi]),
        .d_is_load (ch_is_load[gi]),
        .rr1       (id_rR1),
        .rr2       (id_rR2),
        .q_valid   (ch_valid[gi+1]),
        .q_rf_we   (ch_rf_we[gi+1]),
        .q_wr      (ch_wr[gi+1]),
        .q_is_load (ch_is_load[gi+1]),
        .hit1      (hit1[gi]),
        .hit2      (hit2[gi])
      );
    end
  endgenerate

  // WB is the last slot; its contents only matter through its hit outputs.
  assign unused_wb = ^{ch_valid[3], ch_rf_we[3], ch_wr[3], ch_is_load[3]};

  assign ex_ld    = ch_is_load[1];
  assign load_use = id_valid & ex_ld & ((id_rR1_re & hit1[0]) | (id_rR2_re & hit2[0]));

`ifdef PIPE_FWD_EN
  assign hazard   = load_use;
  assign fwd1_raw = id_rR1_re ? fwd_pick(hit1[0], ex_ld, hit1[1], hit1[2]) : FWD_RF;
  assign fwd2_raw = id_rR2_re ? fwd_pick(hit2[0], ex_ld, hit2[1], hit2[2]) : FWD_RF;
`else
  logic raw_any;
  assign raw_any  = id_valid & ((id_rR1_re & (|hit1)) | (id_rR2_re & (|hit2)));
  assign hazard   = raw_any | load_use;
  assign fwd1_raw = FWD_RF;
  assign fwd2_raw = FWD_RF;
`endif

  assign fwd1_sel = fwd1_raw;
  assign fwd2_sel = fwd2_raw;

  always_comb begin
    act = ACT_RUN;
    if (!cpu_rstn)        act = ACT_RUN;
    else if (mem_busy)    act = ACT_FREEZE;
    else if (ex_br_taken) act = ACT_REDIRECT;
    else if (hazard)      act = ACT_HAZARD;
  end

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (act)
      ACT_FREEZE: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end
      ACT_REDIRECT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      ACT_HAZARD: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      stall_cnt_reg <= '0;
    end else if (pc_stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against an instruction-level
// model of the EX/MEM/WB occupancy; expectations follow PIPE_FWD_EN.
module tb_pipe_ctrl;

  localparam int NREG = 32;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rR1 = '0;
  logic [4:0]  id_rR2 = '0;
  logic        id_rR1_re = 1'b0;
  logic        id_rR2_re = 1'b0;
  logic        id_rf_we = 1'b0;
  logic [4:0]  id_wR = '0;
  logic [1:0]  id_wd_sel = '0;
  logic        ex_br_taken = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwd1_sel;
  logic [1:0]  fwd2_sel;
  logic [31:0] stall_cnt;

  always #5 cpu_clk = ~cpu_clk;

  pipe_ctrl #(.NREG(NREG)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .id_valid    (id_valid),
    .id_rR1      (id_rR1),
    .id_rR2      (id_rR2),
    .id_rR1_re   (id_rR1_re),
    .id_rR2_re   (id_rR2_re),
    .id_rf_we    (id_rf_we),
    .id_wR       (id_wR),
    .id_wd_sel   (id_wd_sel),
    .ex_br_taken (ex_br_taken),
    .mem_busy    (mem_busy),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fwd1_sel    (fwd1_sel),
    .fwd2_sel    (fwd2_sel),
    .stall_cnt   (stall_cnt)
  );

  // Instructions in flight, oldest last.
  typedef struct {
    bit v;
    bit we;
    int r;
    bit ld;
  } ins_t;

  ins_t    m_ex, m_mem, m_wb;
  longint  m_cnt;
  bit      fwd_on;
  int      tests;
  int      fails;
  bit      e_ps, e_is, e_if, e_xf;
  int      e_f1, e_f2;
  longint  base;

  function automatic bit writes(input ins_t s, input int r);
    return s.v && s.we && (s.r == r) && (r != 0);
  endfunction

  function automatic int pick(input int r, input bit re);
    if (!re || !fwd_on) return 0;
    if (writes(m_ex, r) && !m_ex.ld) return 1;
    if (writes(m_mem, r)) return 2;
    if (writes(m_wb, r)) return 3;
    return 0;
  endfunction

  function automatic bit any_writer(input int r);
    return writes(m_ex, r) || writes(m_mem, r) || writes(m_wb, r);
  endfunction

  task automatic model_clear();
    m_ex  = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    m_wb  = '{0, 0, 0, 0};
    m_cnt = 0;
  endtask

  task automatic predict();
    bit haz;
    int r1;
    int r2;
    r1 = int'(id_rR1);
    r2 = int'(id_rR2);
    if (fwd_on)
      haz = id_valid && m_ex.ld && ((id_rR1_re && writes(m_ex, r1)) || (id_rR2_re && writes(m_ex, r2)));
    else
      haz = id_valid && ((id_rR1_re && any_writer(r1)) || (id_rR2_re && any_writer(r2)));
    e_ps = 0; e_is = 0; e_if = 0; e_xf = 0;
    e_f1 = pick(r1, id_rR1_re);
    e_f2 = pick(r2, id_rR2_re);
    if (!cpu_rstn) begin
    end else if (mem_busy) begin
      e_ps = 1; e_is = 1;
    end else if (ex_br_taken) begin
      e_if = 1; e_xf = 1;
    end else if (haz) begin
      e_ps = 1; e_is = 1; e_xf = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    predict();
    $display("[TB] %s v=%0d r1=%0d/%0d r2=%0d/%0d w=%0d/%0d sel=%0d br=%0d busy=%0d -> ps=%0d is=%0d if=%0d xf=%0d f1=%0d f2=%0d cnt=%0d",
             tag, id_valid, id_rR1, id_rR1_re, id_rR2, id_rR2_re, id_wR, id_rf_we, id_wd_sel,
             ex_br_taken, mem_busy, pc_stall, ifid_stall, ifid_flush, idex_flush,
             fwd1_sel, fwd2_sel, stall_cnt);
    check({tag, ".pc_stall"},   {31'd0, pc_stall},   {31'd0, e_ps});
    check({tag, ".ifid_stall"}, {31'd0, ifid_stall}, {31'd0, e_is});
    check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e_if});
    check({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e_xf});
    check({tag, ".fwd1_sel"},   {30'd0, fwd1_sel},   32'(e_f1));
    check({tag, ".fwd2_sel"},   {30'd0, fwd2_sel},   32'(e_f2));
    check({tag, ".stall_cnt"},  stall_cnt,           32'(m_cnt));
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step(input string tag);
    @(negedge cpu_clk);
    check_all(tag);
    @(posedge cpu_clk);
    if (cpu_rstn) begin
      if (e_ps && m_cnt != 64'hFFFF_FFFF) m_cnt++;
      if (!mem_busy) begin
        m_wb  = m_mem;
        m_mem = m_ex;
        if (e_xf) begin
          m_ex = '{0, 0, 0, 0};
        end else begin
          m_ex.v  = id_valid;
          m_ex.we = id_rf_we && (int'(id_wR) < NREG);
          m_ex.r  = int'(id_wR);
          m_ex.ld = (id_wd_sel == 2'd1);
        end
      end
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int r1, input bit re1, input int r2, input bit re2,
                        input bit we, input int wr, input int sel);
    id_valid  = v;
    id_rR1    = 5'(r1);
    id_rR1_re = re1;
    id_rR2    = 5'(r2);
    id_rR2_re = re2;
    id_rf_we  = we;
    id_wR     = 5'(wr);
    id_wd_sel = 2'(sel);
  endtask

  // Present one instruction and keep it in ID while the model says it stalls.
  task automatic issue(input string tag, input int r1, input bit re1, input int r2, input bit re2,
                       input bit we, input int wr, input int sel);
    int n;
    set_id(1, r1, re1, r2, re2, we, wr, sel);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (e_ps && n < 8);
    tests++;
    assert (!e_ps) else begin
      fails++;
      $error("FAIL %s: stall did not clear within %0d cycles (observed stalled, expected released)", tag, n);
    end
  endtask

  task automatic nop(input string tag);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step(tag);
  endtask

  task automatic async_reset();
    cpu_rstn = 1'b0;
    model_clear();
  endtask

  initial begin
`ifdef PIPE_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    tests = 0;
    fails = 0;
    model_clear();

    // Reset state
    #2;
    check_all("reset");
    check("reset_cnt", stall_cnt, 32'd0);
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;
    nop("idle");

    // ALU producer followed by ALU consumer
    base = m_cnt;
    issue("add_r3", 1, 1, 2, 1, 1, 3, 0);
    set_id(1, 3, 1, 5, 1, 1, 4, 0);
    #2;
    check("req032_fwd1", {30'd0, fwd1_sel}, fwd_on ? 32'd1 : 32'd0);
    check("req032_stall", {31'd0, pc_stall}, fwd_on ? 32'd0 : 32'd1);
    issue("add_r4", 3, 1, 5, 1, 1, 4, 0);
    nop("drain");
    check("req032_cnt", stall_cnt, 32'(base + (fwd_on ? 0 : 3)));

    // Load followed by a dependent instruction
    base = m_cnt;
    issue("ld_r6", 1, 1, 0, 0, 1, 6, 1);
    set_id(1, 6, 1, 0, 1, 1, 7, 0);
    #2;
    check("req033_stall", {31'd0, pc_stall}, 32'd1);
    check("req033_xflush", {31'd0, idex_flush}, 32'd1);
    issue("add_r7", 6, 1, 0, 1, 1, 7, 0);
    nop("drain");
    check("req033_cnt", stall_cnt, 32'(base + (fwd_on ? 1 : 3)));

    // r0 never forwards or stalls
    base = m_cnt;
    issue("wr_r0", 1, 1, 2, 1, 1, 0, 0);
    set_id(1, 0, 1, 0, 1, 1, 9, 0);
    #2;
    check("req034_fwd1", {30'd0, fwd1_sel}, 32'd0);
    check("req034_stall", {31'd0, pc_stall}, 32'd0);
    issue("rd_r0", 0, 1, 0, 1, 1, 9, 0);
    check("req034_cnt", stall_cnt, 32'(base));

    // Redirect overrides load-use; freeze overrides both
    issue("ld_r8", 1, 1, 0, 0, 1, 8, 1);
    set_id(1, 8, 1, 0, 0, 1, 11, 0);
    ex_br_taken = 1'b1;
    #2;
    check("req035_br_iff", {31'd0, ifid_flush}, 32'd1);
    check("req035_br_ps", {31'd0, pc_stall}, 32'd0);
    step("br_lu");
    ex_br_taken = 1'b0;
    nop("drain"); nop("drain"); nop("drain");
    issue("ld_r9", 1, 1, 0, 0, 1, 9, 1);
    set_id(1, 9, 1, 0, 0, 1, 12, 0);
    ex_br_taken = 1'b1;
    mem_busy = 1'b1;
    #2;
    check("req035_busy_ps", {31'd0, pc_stall}, 32'd1);
    check("req035_busy_iff", {31'd0, ifid_flush}, 32'd0);
    check("req035_busy_xf", {31'd0, idex_flush}, 32'd0);
    step("busy_br_lu");
    step("busy_br_lu");
    ex_br_taken = 1'b0;
    mem_busy = 1'b0;
    issue("use_r9", 9, 1, 0, 0, 1, 12, 0);
    nop("drain"); nop("drain"); nop("drain");

    // Two producers of r5 in MEM and WB
    issue("w1_r5", 1, 1, 0, 0, 1, 5, 0);
    issue("w2_r5", 2, 1, 0, 0, 1, 5, 0);
    nop("gap");
    set_id(1, 5, 1, 5, 1, 1, 13, 0);
    #2;
    check("req036_fwd1", {30'd0, fwd1_sel}, fwd_on ? 32'd2 : 32'd0);
    check("req036_fwd2", {30'd0, fwd2_sel}, fwd_on ? 32'd2 : 32'd0);
    issue("use_r5", 5, 1, 5, 1, 1, 13, 0);
    nop("drain"); nop("drain"); nop("drain");

    // Reset in the middle of a load-use stall
    issue("ld_r10", 1, 1, 0, 0, 1, 10, 1);
    set_id(1, 10, 1, 0, 0, 1, 14, 0);
    #2;
    check("req037_pre_ps", {31'd0, pc_stall}, 32'd1);
    async_reset();
    #1;
    check("req037_ps", {31'd0, pc_stall}, 32'd0);
    check("req037_xf", {31'd0, idex_flush}, 32'd0);
    check("req037_cnt", stall_cnt, 32'd0);
    step("in_reset");
    cpu_rstn = 1'b1;
    #2;
    check("req037_nohaz", {31'd0, pc_stall}, 32'd0);
    step("after_reset");

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3));
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mem_busy    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
        step("rand_rst");
        cpu_rstn = 1'b1;
      end else begin
        step("rand");
      end
    end
    ex_br_taken = 1'b0;
    mem_busy = 1'b0;
    nop("end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
